// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter:
// default bus widths and the read-owner state encoding.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_RD_IF = 2'd1,
        OWN_RD_EX = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store; load/store has priority
// unless fetch has been denied StarveLimit times in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AddrW       = ADDR_W_DEFAULT,
    parameter int unsigned DataW       = DATA_W_DEFAULT,
    parameter int unsigned StarveLimit = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_i,
    input  logic [AddrW-1:0] if_addr_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [DataW-1:0] if_rdata_o,
    input  logic             ex_req_i,
    input  logic             ex_we_i,
    input  logic [AddrW-1:0] ex_addr_i,
    input  logic [DataW-1:0] ex_wdata_i,
    output logic             ex_gnt_o,
    output logic             ex_rvalid_o,
    output logic [DataW-1:0] ex_rdata_o,
    output logic             mem_ce_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    input  logic [DataW-1:0] mem_rdata_i,
    output logic             hold_if_o
);

    localparam int unsigned CntW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);

    owner_e          state_r;
    owner_e          state_next_s;
    logic [CntW-1:0] starve_cnt_r;
    logic [CntW-1:0] starve_cnt_next_s;
    logic            starved_s;
    logic            if_win_s;
    logic            ex_win_s;

    // Grant selection; reset masks every grant so nothing reaches the RAM.
    always_comb begin
        starved_s = (starve_cnt_r == StarveMax);
        if_win_s  = 1'b0;
        ex_win_s  = 1'b0;
        if (rst) begin
            if_win_s = 1'b0;
            ex_win_s = 1'b0;
        end else if (ex_req_i && !(if_req_i && starved_s)) begin
            ex_win_s = 1'b1;
        end else if (if_req_i) begin
            if_win_s = 1'b1;
        end else begin
            if_win_s = 1'b0;
            ex_win_s = 1'b0;
        end
    end

    // RAM port mux driven by the winner.
    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {AddrW{1'b0}};
        mem_wdata_o = {DataW{1'b0}};
        if (ex_win_s) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = ex_we_i;
            mem_addr_o  = ex_addr_i;
            mem_wdata_o = ex_wdata_i;
        end else if (if_win_s) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = 1'b0;
            mem_addr_o  = if_addr_i;
            mem_wdata_o = {DataW{1'b0}};
        end else begin
            mem_ce_o = 1'b0;
        end
    end

    // Next owner and starvation count, both decided by this cycle's grant.
    always_comb begin
        state_next_s      = OWN_IDLE;
        starve_cnt_next_s = {CntW{1'b0}};
        if (if_win_s) begin
            state_next_s = OWN_RD_IF;
        end else if (ex_win_s && !ex_we_i) begin
            state_next_s = OWN_RD_EX;
        end else begin
            state_next_s = OWN_IDLE;
        end
        if (if_req_i && !if_win_s) begin
            starve_cnt_next_s = starved_s ? starve_cnt_r : (starve_cnt_r + CntW'(1));
        end else begin
            starve_cnt_next_s = {CntW{1'b0}};
        end
    end

    // Owner and starvation registers; a reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= OWN_IDLE;
            starve_cnt_r <= {CntW{1'b0}};
        end else begin
            state_r      <= state_next_s;
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // Route returning RAM data to whoever owned last cycle's read.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = {DataW{1'b0}};
        ex_rvalid_o = 1'b0;
        ex_rdata_o  = {DataW{1'b0}};
        case (state_r)
            OWN_RD_IF: begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
            OWN_RD_EX: begin
                ex_rvalid_o = 1'b1;
                ex_rdata_o  = mem_rdata_i;
            end
            default: begin
                if_rvalid_o = 1'b0;
                ex_rvalid_o = 1'b0;
            end
        endcase
    end

    assign if_gnt_o  = if_win_s;
    assign ex_gnt_o  = ex_win_s;
    assign hold_if_o = if_req_i && !if_win_s && !rst;

endmodule
